// File: rtl/hub75_row_scheduler_if.sv
// Handshake between the row scheduler and the HUB75 shift-out transmitter:
// start pulse plus row/bit-plane descriptor out, ready back.
interface hub75_row_scheduler_if #(
    parameter int addr_width_p    = 12,
    parameter int pix_bit_width_p = 3
);
    logic                       i_tx_ready;
    logic                       o_tx_start;
    logic [addr_width_p-1:0]    o_init_addr;
    logic [pix_bit_width_p-1:0] o_pix_bit;

    modport master (
        input  i_tx_ready,
        output o_tx_start,
        output o_init_addr,
        output o_pix_bit
    );

    modport slave (
        output i_tx_ready,
        input  o_tx_start,
        input  o_init_addr,
        input  o_pix_bit
    );
endinterface

// File: rtl/hub75_row_scheduler.sv
// HUB75 binary-coded-modulation scheduler: per row and bit-plane it starts a
// shift-out, waits for latch completion, then enables the LEDs for base<<plane cycles.
module hub75_row_scheduler #(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2,
    parameter int oe_wd_p    = 8,
    localparam int rows_p          = vpixel_p / segments_p,
    localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
    localparam int row_wd_p        = $clog2(rows_p),
    localparam int pix_bit_width_p = $clog2(bpp_p)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [oe_wd_p-1:0]  i_oe_base,
    hub75_row_scheduler_if.master tx,
    output logic [row_wd_p-1:0] o_row_addr,
    output logic                o_oe_n,
    output logic                o_frame_done,
    output logic                o_busy
);

    localparam int dc_wd_p = oe_wd_p + bpp_p - 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        GUARD,
        DISPLAY,
        NEXT
    } state_t;

    state_t                     state, state_next;
    logic [row_wd_p-1:0]        row_cnt, row_next;
    logic [pix_bit_width_p-1:0] bit_cnt, bit_next;
    logic [oe_wd_p-1:0]         oe_base_int, oe_base_next;
    logic [dc_wd_p-1:0]         disp_cnt, disp_next;
    logic                       frame_end, frame_end_next;
    logic                       advance;
    logic                       wrap;
    logic                       last_bit;
    logic                       last_row;

    assign last_bit = (bit_cnt == pix_bit_width_p'(bpp_p - 1));
    assign last_row = (row_cnt == row_wd_p'(rows_p - 1));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_next     = state;
        row_next       = row_cnt;
        bit_next       = bit_cnt;
        oe_base_next   = oe_base_int;
        disp_next      = disp_cnt;
        frame_end_next = frame_end;
        advance        = 1'b0;
        wrap           = 1'b0;

        case (state)
            IDLE: begin
                if (i_enable && tx.i_tx_ready) begin
                    state_next   = START;
                    oe_base_next = i_oe_base;
                end
            end
            START:     state_next = WAIT_ACK;
            WAIT_ACK:  if (!tx.i_tx_ready) state_next = WAIT_DONE;
            WAIT_DONE: if (tx.i_tx_ready)  state_next = GUARD;
            GUARD: begin
                if (oe_base_int == '0) begin
                    state_next = NEXT;
                    advance    = 1'b1;
                end else begin
                    state_next = DISPLAY;
                    disp_next  = (dc_wd_p'(oe_base_int) << bit_cnt) - dc_wd_p'(1);
                end
            end
            DISPLAY: begin
                if (disp_cnt == '0) begin
                    state_next = NEXT;
                    advance    = 1'b1;
                end else begin
                    disp_next = disp_cnt - dc_wd_p'(1);
                end
            end
            NEXT: begin
                // Counters already moved on entry; waiting here for ready must not move them again.
                if (frame_end && !i_enable) begin
                    state_next     = IDLE;
                    frame_end_next = 1'b0;
                end else if (tx.i_tx_ready) begin
                    state_next     = START;
                    frame_end_next = 1'b0;
                    if (frame_end) oe_base_next = i_oe_base;
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            bit_next = last_bit ? '0 : bit_cnt + pix_bit_width_p'(1);
            if (last_bit) row_next = last_row ? '0 : row_cnt + row_wd_p'(1);
            wrap           = last_bit && last_row;
            frame_end_next = wrap;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state           <= IDLE;
            row_cnt         <= '0;
            bit_cnt         <= '0;
            oe_base_int     <= '0;
            disp_cnt        <= '0;
            frame_end       <= 1'b0;
            tx.o_tx_start   <= 1'b0;
            tx.o_init_addr  <= '0;
            tx.o_pix_bit    <= '0;
            o_row_addr      <= '0;
            o_oe_n          <= 1'b1;
            o_frame_done    <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            state           <= state_next;
            row_cnt         <= row_next;
            bit_cnt         <= bit_next;
            oe_base_int     <= oe_base_next;
            disp_cnt        <= disp_next;
            frame_end       <= frame_end_next;
            // Outputs decode the next state so they line up with the state they describe.
            tx.o_tx_start   <= (state_next == START);
            tx.o_init_addr  <= addr_width_p'(row_next) * addr_width_p'(hpixel_p);
            tx.o_pix_bit    <= bit_next;
            o_oe_n          <= (state_next != DISPLAY);
            o_frame_done    <= wrap;
            o_busy          <= (state_next != IDLE);
            if (state_next == GUARD) o_row_addr <= row_cnt;
        end
    end

endmodule

// File: tb/tb_hub75_row_scheduler.sv
// Scoreboard bench for hub75_row_scheduler: stimulus queues expected starts and
// display pulses, monitors pop and compare as the DUT produces them.
module tb_hub75_row_scheduler;

    localparam int addr_w = 12;
    localparam int pix_w  = 3;
    localparam int row_w  = 5;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             enable   = 1'b1;
    logic [7:0]       oe_base  = 8'd4;
    logic [row_w-1:0] row_addr;
    logic             oe_n;
    logic             frame_done;
    logic             busy;

    hub75_row_scheduler_if #(.addr_width_p(addr_w), .pix_bit_width_p(pix_w)) tx_if ();

    hub75_row_scheduler #(
        .hpixel_p  (64),
        .vpixel_p  (64),
        .bpp_p     (8),
        .segments_p(2),
        .oe_wd_p   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (enable),
        .i_oe_base   (oe_base),
        .tx          (tx_if.master),
        .o_row_addr  (row_addr),
        .o_oe_n      (oe_n),
        .o_frame_done(frame_done),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int pbit;} start_t;
    typedef struct {int len; int row;} oe_t;

    start_t exp_start[$];
    oe_t    exp_oe[$];

    int checks          = 0;
    int errors          = 0;
    int start_cnt       = 0;
    int frame_cnt       = 0;
    int starts_in_frame = 0;
    int tx_delay        = 140;
    int cyc             = 0;
    int rise_cyc        = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, start_cnt >= target, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic push_frame(input int base, input bit with_display);
        for (int r = 0; r < 32; r++) begin
            for (int p = 0; p < 8; p++) begin
                exp_start.push_back('{r * 64, p});
                if (with_display) exp_oe.push_back('{base << p, r});
            end
        end
    endtask

    // Transmitter model: ready drops after a start and returns tx_delay cycles later.
    initial begin
        tx_if.i_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_if.o_tx_start) begin
                tx_if.i_tx_ready = 1'b0;
                repeat (tx_delay) @(negedge clk);
                tx_if.i_tx_ready = 1'b1;
                rise_cyc = cyc;
            end
        end
    end

    // Start / frame-end monitor.
    initial begin
        start_t e;
        logic   prev_fd;
        prev_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                starts_in_frame = 0;
            end else begin
                if (tx_if.o_tx_start) begin
                    start_cnt++;
                    starts_in_frame++;
                    check("start_expected", exp_start.size() > 0, 1);
                    if (exp_start.size() > 0) begin
                        e = exp_start.pop_front();
                        check("start_init_addr", tx_if.o_init_addr, e.addr);
                        check("start_pix_bit", tx_if.o_pix_bit, e.pbit);
                    end
                end
                if (frame_done) begin
                    frame_cnt++;
                    check("starts_per_frame", starts_in_frame, 256);
                    check("frame_done_width", prev_fd, 0);
                    starts_in_frame = 0;
                end
            end
            prev_fd = frame_done;
        end
    end

    // Display-pulse monitor: length, guard gap and row stability.
    initial begin
        oe_t e;
        int  len;
        bit  active;
        bit  row_moved;
        active = 1'b0;
        len    = 0;
        e      = '{-1, -1};
        row_moved = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                len    = 0;
            end else if (!oe_n) begin
                if (!active) begin
                    active    = 1'b1;
                    len       = 0;
                    row_moved = 1'b0;
                    check("oe_expected", exp_oe.size() > 0, 1);
                    e = (exp_oe.size() > 0) ? exp_oe.pop_front() : '{-1, -1};
                    check("guard_gap", cyc - rise_cyc, 2);
                    check("oe_row_addr", row_addr, e.row);
                end else if (row_addr != row_w'(e.row)) begin
                    row_moved = 1'b1;
                end
                len++;
            end else if (active) begin
                active = 1'b0;
                check("oe_len", len, e.len);
                check("row_stable", row_moved, 0);
            end
        end
    end

    initial begin
        int base;
        int f0;

        // Reset held with enable high.
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_oe_n", oe_n, 1);
            check("rst_tx_start", tx_if.o_tx_start, 0);
            check("rst_busy", busy, 0);
            check("rst_row_addr", row_addr, 0);
            check("rst_frame_done", frame_done, 0);
        end

        // Row 0 all planes with base 4, then row 1 plane 0.
        for (int p = 0; p < 8; p++) begin
            exp_start.push_back('{0, p});
            exp_oe.push_back('{4 << p, 0});
        end
        exp_start.push_back('{64, 0});
        exp_oe.push_back('{4, 1});
        rst = 1'b0;
        wait_starts(9, 5000, "startup_starts");
        check("busy_running", busy, 1);

        // Reset in the middle of row 1 plane 0 display.
        begin
            int n = 0;
            while (oe_n && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("reach_display", oe_n, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_oe_n", oe_n, 1);
        check("midrst_busy", busy, 0);
        check("midrst_tx_start", tx_if.o_tx_start, 0);
        check("midrst_row_addr", row_addr, 0);
        check("midrst_init_addr", tx_if.o_init_addr, 0);
        check("midrst_pix_bit", tx_if.o_pix_bit, 0);

        // Two frames: base 1, then base 2 picked up only at the frame wrap; enable drops in frame 2.
        tx_delay = 4;
        oe_base  = 8'd1;
        enable   = 1'b1;
        push_frame(1, 1'b1);
        push_frame(2, 1'b1);
        base = start_cnt;
        f0   = frame_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_starts(base + 20, 5000, "frame1_progress");
        oe_base = 8'd2;
        wait_starts(base + 256 + 80, 40000, "frame2_row10");
        enable = 1'b0;
        wait_idle(30000, "drop_reaches_idle");
        check("drop_frames", frame_cnt - f0, 2);
        check("drop_starts", start_cnt - base, 512);
        repeat (200) @(negedge clk);
        check("idle_no_more_starts", start_cnt - base, 512);
        check("idle_busy", busy, 0);
        check("idle_oe_n", oe_n, 1);
        check("start_queue_drained", exp_start.size(), 0);
        check("oe_queue_drained", exp_oe.size(), 0);

        // Zero base: rows advance, LEDs never enabled; enable dropped right after the first start.
        oe_base = 8'd0;
        push_frame(0, 1'b0);
        base = start_cnt;
        f0   = frame_cnt;
        enable = 1'b1;
        wait_starts(base + 1, 1000, "zero_first_start");
        enable = 1'b0;
        wait_idle(20000, "zero_reaches_idle");
        check("zero_starts", start_cnt - base, 256);
        check("zero_frames", frame_cnt - f0, 1);
        check("zero_queue_drained", exp_start.size(), 0);
        check("zero_oe_n", oe_n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
